wb_ram_slave: RTL

Wishbone classic slave with a small on-chip word RAM behind it. It answers the requests issued by the CPU-side WB master through the interconnect, and occupies a slave slot such as S0 (memory).
Supports byte-lane writes, full-word reads, a parameterised number of wait states, CYC-drop abort, and an error response for out-of-range addresses.

---
 rtl/wb_ram_pkg.sv | 21 ++
 rtl/wb_ram_slave_if.sv | 26 ++
 rtl/wb_ram_array.sv | 35 +++
 rtl/wb_ram_slave.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/wb_ram_pkg.sv
// Shared types for the Wishbone RAM slave: FSM states, wait-counter width
// and the two-bit response encoding that drives ACK/ERR.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Wait-state counter holds LATENCY in the range 0..15.
    localparam int CNT_W = 4;

    // Bit 0 drives ACK, bit 1 drives ERR, so the two can never be high together.
    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10
    } resp_e;

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between one master and the RAM slave.
// Signal directions are named from the slave's point of view.
interface wb_ram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic                    stb_i;
    logic                    cyc_i;
    logic                    ack_o;
    logic                    err_o;

    modport master (
        output dat_i, adr_i, we_i, sel_i, stb_i, cyc_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  dat_i, adr_i, we_i, sel_i, stb_i, cyc_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_ram_array.sv
// Word RAM with per-byte write enables and a registered, read-enabled read port.
// Storage and read register carry no reset so the array maps onto block RAM.
module wb_ram_array #(
    parameter int MEM_ADDR_W = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic [MEM_ADDR_W-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    // One narrow array per byte lane keeps each lane a simple single-writer RAM.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && sel[gi]) begin
                mem[addr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
                rd_q <= mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave in front of a byte-writable word RAM: programmable
// wait states, CYC-drop abort and ERR for addresses beyond the RAM.
module wb_ram_slave
    import wb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_ADDR_W = 8,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           arst,
    wb_ram_slave_if.slave  bus
);
    localparam int LANES = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [LANES-1:0]        sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    oor_q, oor_d;
    resp_e                   resp_q, resp_d;
    logic                    rdsel_q, rdsel_d;

    logic                    req;
    logic [MEM_ADDR_W-1:0]   live_addr;
    logic                    live_oor;
    logic [1:0]              unused_adr_lsb;

    logic                    go_resp;
    logic [MEM_ADDR_W-1:0]   acc_addr;
    logic                    acc_we;
    logic [LANES-1:0]        acc_sel;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_oor;
    logic                    ram_we;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign req            = bus.cyc_i & bus.stb_i;
    assign live_addr      = bus.adr_i[MEM_ADDR_W+1:2];
    assign live_oor       = |bus.adr_i[ADDR_WIDTH-1:MEM_ADDR_W+2];
    assign unused_adr_lsb = bus.adr_i[1:0];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            resp_q  <= RESP_NONE;
            rdsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            resp_q  <= resp_d;
            rdsel_q <= rdsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With zero wait states the access happens on the capture edge itself,
    // so the live bus fields stand in for the not-yet-latched copies.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        if (state_q == IDLE && req) begin
            addr_d  = live_addr;
            we_d    = bus.we_i;
            sel_d   = bus.sel_i;
            wdata_d = bus.dat_i;
            oor_d   = live_oor;
        end

        acc_addr  = (state_q == IDLE) ? live_addr   : addr_q;
        acc_we    = (state_q == IDLE) ? bus.we_i    : we_q;
        acc_sel   = (state_q == IDLE) ? bus.sel_i   : sel_q;
        acc_wdata = (state_q == IDLE) ? bus.dat_i   : wdata_q;
        acc_oor   = (state_q == IDLE) ? live_oor    : oor_q;

        go_resp = (state_d == RESP) && (state_q != RESP);
        ram_we  = go_resp && arst && !acc_oor && acc_we;
        ram_re  = go_resp && arst && !acc_oor && !acc_we;

        resp_d  = RESP_NONE;
        rdsel_d = rdsel_q;
        if (go_resp) begin
            resp_d  = acc_oor ? RESP_ERR : RESP_OK;
            rdsel_d = !acc_oor && !acc_we;
        end
    end

    wb_ram_array #(
        .MEM_ADDR_W (MEM_ADDR_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .addr  (acc_addr),
        .we    (ram_we),
        .sel   (acc_sel),
        .wdata (acc_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // The RAM read register only loads on read responses, so it already holds
    // the last read word; rdsel_q zeroes it after writes, errors and reset.
    assign bus.dat_o = rdsel_q ? ram_rdata : '0;
    assign bus.ack_o = (resp_q == RESP_OK);
    assign bus.err_o = (resp_q == RESP_ERR);

endmodule
